// File: rtl/ysyx_22050133_imem_resp.sv
// ---------------------------------------------------------------------------
// ysyx_22050133_imem_resp
// Fixed-latency instruction memory responder. A fetch request is accepted in
// IDLE, waits out LATENCY cycles, then presents the aligned 64-bit word that
// holds the addressed instruction. The word is held until the consumer takes
// it. Illegal addresses return a zero word with fault_o set.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   pc_valid_i / pc   fetch request (byte address)
//   pc_ready_o        high only in IDLE (and not while in reset)
//   inst64            aligned 64-bit word; selecting the 32-bit half is left
//                     to the consumer
//   inst_valid_o      response valid, held until inst_ready_i
//   inst_ready_i      consumer takes the response
//   fault_o           access fault, meaningful only with inst_valid_o
//   ld_en/addr/data   word write port, independent of the FSM and of reset
//
// LATENCY must lie in 1..15 (4-bit counter).
// ---------------------------------------------------------------------------
module ysyx_22050133_imem_resp #(
  parameter int          LATENCY = 2,
  parameter int          DEPTH   = 1024,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pc_valid_i,
  input  logic [63:0]   pc,
  output logic          pc_ready_o,
  output logic [63:0]   inst64,
  output logic          inst_valid_o,
  input  logic          inst_ready_i,
  output logic          fault_o,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [63:0]   ld_data
);

  localparam logic [63:0] DEPTH_W = 64'(DEPTH);
  localparam logic [3:0]  CNT_LD  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [63:0]  pc_cap_q, pc_cap_d;
  logic [63:0]  inst_q, inst_d;
  logic         fault_q, fault_d;

  logic [63:0]  mem [DEPTH];

  // Storage has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  // Address to latch on RESP entry. With LATENCY==1 entry happens on the
  // accept edge, so the live pc is used; otherwise the captured one.
  logic [63:0]   addr_sel;
  logic [63:0]   off;
  logic          legal;
  logic [AW-1:0] rd_idx;
  logic [63:0]   rd_word;

  always_comb begin
    addr_sel = (state_q == IDLE) ? pc : pc_cap_q;
    off      = addr_sel - BASE;
    legal    = (addr_sel >= BASE) && ((off >> 3) < DEPTH_W) &&
               (addr_sel[1:0] == 2'b00);
    rd_idx   = off[AW+2:3];
    // Write-first: a same-edge store to the latched word wins.
    rd_word  = (ld_en && (ld_addr == rd_idx)) ? ld_data : mem[rd_idx];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_cap_d = pc_cap_q;
    inst_d   = inst_q;
    fault_d  = fault_q;
    unique case (state_q)
      IDLE: begin
        if (pc_valid_i && pc_ready_o) begin
          pc_cap_d = pc;
          if (LATENCY == 1) begin
            state_d = RESP;
            inst_d  = legal ? rd_word : 64'd0;
            fault_d = ~legal;
          end else begin
            cnt_d   = CNT_LD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          inst_d  = legal ? rd_word : 64'd0;
          fault_d = ~legal;
        end
      end
      RESP: begin
        // Retiring edge goes to IDLE; pc_ready_o was low this cycle, so a
        // new request can only be taken on the following edge.
        if (inst_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      pc_cap_q <= 64'd0;
      inst_q   <= 64'd0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pc_cap_q <= pc_cap_d;
      inst_q   <= inst_d;
      fault_q  <= fault_d;
    end
  end

  assign pc_ready_o   = (state_q == IDLE) && rst;
  assign inst_valid_o = (state_q == RESP);
  assign inst64       = inst_q;
  assign fault_o      = fault_q;

endmodule

// File: doc/ysyx_22050133_imem_resp.md
YSYX_22050133_IMEM_RESP -- requirements
Module: ysyx_22050133_imem_resp

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to response valid (legal 1..15).
REQ-002 SHALL have parameter DEPTH, default 1024, meaning number of 64-bit memory words.
REQ-003 SHALL have parameter BASE, default 64'h8000_0000, meaning byte address of word 0.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port pc_valid_i  input  1  fetch request valid.
REQ-007 SHALL have port pc  input  64  fetch byte address.
REQ-008 SHALL have port pc_ready_o  output  1  request accepted this cycle when high with pc_valid_i.
REQ-009 SHALL have port inst64  output  64  aligned 64-bit word containing the addressed instruction.
REQ-010 SHALL have port inst_valid_o  output  1  response valid.
REQ-011 SHALL have port inst_ready_i  input  1  consumer takes response.
REQ-012 SHALL have port fault_o  output  1  response is an access fault; valid only with inst_valid_o.
REQ-013 SHALL have ports ld_en input 1, ld_addr input log2(DEPTH), ld_data input 64: word preload/write port.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 SHALL drive pc_ready_o=1 only in IDLE; 0 in WAIT and RESP.
REQ-016 IDLE: on pc_valid_i && pc_ready_o SHALL capture pc, load counter with LATENCY-1, enter WAIT (or RESP directly if LATENCY==1).
REQ-017 WAIT: SHALL decrement counter each cycle; when counter==1 SHALL enter RESP next edge.
REQ-018 Request accepted at edge T SHALL produce inst_valid_o=1 starting exactly at edge T+LATENCY.
REQ-019 On entry to RESP SHALL register inst64 = mem[(pc_cap-BASE)>>3] and fault_o=0 for a legal address.
REQ-020 Address SHALL be illegal if pc_cap < BASE, (pc_cap-BASE)>>3 >= DEPTH, or pc_cap[1:0]!=0; then inst64=0, fault_o=1.
REQ-021 pc[2]=1 SHALL be legal; word selection is the consumer's job.
REQ-022 RESP: inst64, fault_o, inst_valid_o SHALL hold stable until inst_ready_i=1; that edge returns to IDLE.
REQ-023 Back-to-back: new request SHALL NOT be accepted in the cycle the response retires; earliest acceptance is the following IDLE cycle.
REQ-024 ld_en SHALL write mem[ld_addr]=ld_data at the edge in any state, independent of the FSM.
REQ-025 If ld_en targets the word being latched on RESP entry in the same cycle, SHALL return the new ld_data (write-first).
REQ-026 ld_en to a word already latched in RESP SHALL NOT alter the held inst64.
REQ-027 pc changes while not accepted SHALL have no effect.

Reset
REQ-028 rst=0 SHALL immediately force state IDLE, counter 0, inst_valid_o=0, fault_o=0, inst64=0, pc_ready_o=1 (pc_ready_o gated 0 while rst=0).
REQ-029 Reset mid-WAIT or mid-RESP SHALL discard the pending request with no response after release.
REQ-030 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-031 Preload mem[0]=64'h0000_0013_0000_0093; request pc=64'h8000_0000 at T, inst_ready_i=1 -> inst_valid_o=1 at T+2, inst64=64'h0000_0013_0000_0093, fault_o=0, pc_ready_o=1 at T+3.
REQ-032 Request pc=64'h8000_0004 with inst_ready_i=0 for 5 cycles -> inst_valid_o held, inst64 constant, pc_ready_o=0 throughout, retire on first inst_ready_i=1.
REQ-033 Requests pc=64'h7FFF_FFF8, 64'h8000_2000 (DEPTH=1024), 64'h8000_0002 -> each fault_o=1, inst64=0.
REQ-034 LATENCY=1 and LATENCY=15 builds, pc=64'h8000_0008 -> inst_valid_o at T+1 and T+15 respectively.
REQ-035 Assert rst=0 during WAIT, release -> no inst_valid_o pulse, pc_ready_o=1, next request served normally.
REQ-036 ld_en to word 3 with data 64'hDEAD_BEEF_CAFE_F00D in RESP-entry cycle of pc=64'h8000_0018 -> inst64=64'hDEAD_BEEF_CAFE_F00D.
